divider: RTL and testbench
==========================

# divider

Iterative 32-bit integer divider that responds to the CPU's begin/end coprocessor handshake. The core pulses `div_begin` for DIV/DIVU; this block latches the operands and runs one restoring-division step per clock. It then presents quotient and remainder with a one-cycle `div_end` strobe that the core uses as its write-back enable. It sits beside the multiplier in the execute stage and shares its clock.

## Interface
- `WIDTH`, 32, operand, quotient and remainder width; only 32 is supported and verified.
- `clk`  in  1  clock; all state changes on the rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `div_begin`  in  1  start request; the core drives it as a single-cycle pulse.
- `div_signed`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with `div_begin`.
- `div_op1`  in  WIDTH  dividend; sampled with `div_begin`.
- `div_op2`  in  WIDTH  divisor; sampled with `div_begin`.
- `quotient`  out  WIDTH  result quotient; registered.
- `remainder`  out  WIDTH  result remainder; registered.
- `div_busy`  out  1  high while an operation is in progress.
- `div_end`  out  1  one-cycle completion strobe; results are valid from this cycle on.

## Operation
- States:
  - IDLE: accepting requests.
  - CALC: iterating, driven by a 5-bit step counter.
  - DONE: lasts exactly 1 cycle, `div_end`=1.
- Transitions:
  - IDLE→CALC when `div_begin`=1.
  - CALC→DONE after 32 steps.
  - DONE→CALC if `div_begin`=1 in the DONE cycle (back-to-back start).
  - DONE→IDLE otherwise.
- `div_begin` is ignored in CALC. It does not queue, and no error is flagged.
- On accept, the block latches:
  - |op1| and |op2| magnitudes, with two's-complement negation applied only when `div_signed`=1 and the operand MSB is 1;
  - the quotient sign, op1.MSB XOR op2.MSB;
  - the remainder sign, op1.MSB;
  - a divide-by-zero flag, (op2==0);
  - op1 unchanged.
- Each CALC step (restoring division):
  - 64-bit working register {R,Q}: shift left 1 bit.
  - Compute 33-bit difference D = {1'b0,R[31:0]} − {1'b0,|op2|}.
  - If D is non-negative: R ← D[31:0] and Q[0] ← 1. Otherwise restore R and Q[0] ← 0.
  - Step counter increments and wraps 31→0. The wrap marks the end of the last step.
- Final fixup, registered into the outputs on the CALC→DONE edge:
  - Signed: quotient is negated if the quotient sign is 1; remainder is negated if the remainder sign is 1. Quotient truncates toward zero; the remainder takes the sign of the dividend (MIPS semantics).
  - Divide by zero, any mode: quotient = 0xFFFFFFFF, remainder = latched op1 unmodified. Latency is unchanged.
  - 0x80000000 / 0xFFFFFFFF signed: quotient = 0x80000000, remainder = 0. This is the natural wrap result; no trap.
- `quotient` and `remainder` hold their values from DONE until the next DONE. A new request does not disturb them until it completes.

## Timing
- Reset, synchronous, in any state, including mid-CALC:
  - state → IDLE, counter → 0, flags → 0;
  - `quotient`=0, `remainder`=0, `div_busy`=0, `div_end`=0.
  - An in-flight operation is discarded with no `div_end`.
- With `div_begin` sampled high at edge E0:
  - `div_busy`=1 from E0 through the DONE cycle inclusive (33 cycles);
  - `div_end`=1 in the cycle after edge E32 only, 33 cycles after acceptance;
  - results are readable in the same cycle as `div_end`.
- Back-to-back: with `div_begin` high in the DONE cycle, the next `div_end` comes 33 cycles after that edge and `div_busy` stays high continuously.
- `div_begin` held high for multiple cycles: only the first is accepted. If it is still high in DONE, a second operation starts; the core must pulse.
- Operand inputs are don't-care except in the accept cycle.
- No combinational path exists from any input to any output.

## Test plan
- Unsigned 100 / 7, `div_signed`=0, begin at cycle 0 → `div_end` at cycle 33 only, quotient=14, remainder=2, `div_busy` high for cycles 1–33.
- Signed 0xFFFFFFF9 (−7) / 2 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). Then 7 / 0xFFFFFFFE → quotient=0xFFFFFFFD, remainder=1.
- Divide by zero: 0x00001234 / 0 in both modes → quotient=0xFFFFFFFF, remainder=0x00001234, latency 33.
- Overflow and unsigned extremes:
  - signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0;
  - unsigned 0xFFFFFFFF / 0xFFFFFFFF → quotient=1, remainder=0;
  - unsigned 0x80000000 / 0xFFFFFFFF → quotient=0, remainder=0x80000000.
- Handshake abuse:
  - second `div_begin` with different operands at cycle 10 of CALC → ignored, first result unaffected;
  - `div_begin` in the DONE cycle → second `div_end` exactly 33 cycles later;
  - first results hold until then.
- Reset mid-operation: `resetn`=0 at cycle 15 of CALC → next cycle all outputs 0, state IDLE, no `div_end`. A new request after reset completes normally in 33 cycles.

Source files
------------

// File: rtl/divider.sv
// Iterative 32-bit restoring divider with a begin/end coprocessor handshake.
// One quotient bit per clock; results and div_end are registered on the last step.
// state | meaning
// IDLE  | waiting for div_begin
// CALC  | 32 restoring steps, div_begin ignored
// DONE  | one cycle, div_end=1, may accept a back-to-back request
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_begin,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_op1,
  input  logic [WIDTH-1:0] div_op2,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_busy,
  output logic             div_end
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_op1;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;
  logic             r_end;

  logic [WIDTH-1:0] w_shift_r;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_next_r;
  logic [WIDTH-1:0] w_next_q;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [WIDTH-1:0] w_fin_q;
  logic [WIDTH-1:0] w_fin_r;

  // One step: shift {R,Q} left, trial-subtract the divisor magnitude.
  assign w_shift_r = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
  assign w_diff    = {1'b0, w_shift_r} - {1'b0, r_dsr};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_next_r  = w_ge ? w_diff[WIDTH-1:0] : w_shift_r;
  assign w_next_q  = {r_quo[WIDTH-2:0], w_ge};

  assign w_mag1 = (div_signed && div_op1[WIDTH-1]) ? -div_op1 : div_op1;
  assign w_mag2 = (div_signed && div_op2[WIDTH-1]) ? -div_op2 : div_op2;

  // Divide-by-zero overrides the sign fixup; 0x80000000/-1 wraps naturally.
  assign w_fin_q = r_dz ? '1    : (r_qneg ? -w_next_q : w_next_q);
  assign w_fin_r = r_dz ? r_op1 : (r_rneg ? -w_next_r : w_next_r);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dsr       <= '0;
      r_op1       <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_dz        <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_end       <= 1'b0;
    end else begin
      r_end <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (div_begin) begin
            r_state <= S_CALC;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_mag1;
            r_dsr   <= w_mag2;
            r_op1   <= div_op1;
            r_qneg  <= div_signed & (div_op1[WIDTH-1] ^ div_op2[WIDTH-1]);
            r_rneg  <= div_signed & div_op1[WIDTH-1];
            r_dz    <= (div_op2 == '0);
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_CALC: begin
          r_rem <= w_next_r;
          r_quo <= w_next_q;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state     <= S_DONE;
            r_quotient  <= w_fin_q;
            r_remainder <= w_fin_r;
            r_end       <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_busy  = r_busy;
  assign div_end   = r_end;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: vector table plus handshake/reset sequences,
// with a scoreboard of expected results and completion cycles.
module tb_divider;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        div_begin = 1'b0;
  logic        div_signed = 1'b0;
  logic [31:0] div_op1 = '0;
  logic [31:0] div_op2 = '0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_busy;
  logic        div_end;

  divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .div_begin (div_begin),
    .div_signed(div_signed),
    .div_op1   (div_op1),
    .div_op2   (div_op2),
    .quotient  (quotient),
    .remainder (remainder),
    .div_busy  (div_busy),
    .div_end   (div_end)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: MIPS DIV/DIVU with divide-by-zero and overflow conventions.
  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    logic signed [31:0] sa, sbv;
    sa  = a;
    sbv = b;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (s) begin
      q = sa / sbv;
      r = sa % sbv;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Drives one begin pulse from the current point in time; accepted on the next edge.
  task automatic drive_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r, input bit push);
    exp_t e;
    div_signed = s;
    div_op1    = a;
    div_op2    = b;
    div_begin  = 1'b1;
    if (push) begin
      e.q   = q;
      e.r   = r;
      e.cyc = cyc + 33;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    div_begin  = 1'b0;
    div_op1    = $urandom;
    div_op2    = $urandom;
    div_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: %0d results outstanding at cycle %0d", sb.size(), cyc);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (div_end === 1'b1) begin
      if (sb.size() == 0) begin
        check1("end_without_request", div_end, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", quotient, mon_e.q);
        check("remainder", remainder, mon_e.r);
        check("end_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  vec_t tbl[13];

  initial begin
    logic [31:0] eq, er, a, b;
    logic        s;

    tbl[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2};
    tbl[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF};
    tbl[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1};
    tbl[3]  = '{1'b0, 32'h00001234,  32'd0,         32'hFFFFFFFF,  32'h00001234};
    tbl[4]  = '{1'b1, 32'h00001234,  32'd0,         32'hFFFFFFFF,  32'h00001234};
    tbl[5]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0};
    tbl[6]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'd0};
    tbl[7]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000};
    tbl[8]  = '{1'b1, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFF9};
    tbl[9]  = '{1'b0, 32'd0,         32'd5,         32'd0,         32'd0};
    tbl[10] = '{1'b1, 32'h80000000,  32'd1,         32'h80000000,  32'd0};
    tbl[11] = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0};
    tbl[12] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_quotient", quotient, 32'h0);
    check("rst_remainder", remainder, 32'h0);
    check1("rst_busy", div_busy, 1'b0);
    check1("rst_end", div_end, 1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // 100/7 with cycle-by-cycle busy tracking
    @(posedge clk);
    #1;
    drive_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      check1("busy_during_op", div_busy, 1'b1);
    end
    @(negedge clk);
    check1("busy_after_done", div_busy, 1'b0);
    check1("end_after_done", div_end, 1'b0);
    wait_done();

    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      drive_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, 1'b1);
      wait_done();
    end

    // begin during CALC is ignored
    @(posedge clk);
    #1;
    drive_op(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    drive_op(1'b1, 32'd7, 32'd3, 32'd0, 32'd0, 1'b0);
    wait_done();
    repeat (40) @(negedge clk);
    check("sb_empty_after_ignore", sb.size(), 32'd0);

    // back-to-back start in the DONE cycle; first results hold meanwhile
    @(posedge clk);
    #1;
    drive_op(1'b0, 32'd50, 32'd7, 32'd7, 32'd1, 1'b1);
    for (int i = 0; i < 40 && div_end !== 1'b1; i++) @(negedge clk);
    check1("b2b_first_end", div_end, 1'b1);
    drive_op(1'b0, 32'd200, 32'd9, 32'd22, 32'd2, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_end === 1'b1) break;
      check("b2b_hold_q", quotient, 32'd7);
      check("b2b_hold_r", remainder, 32'd1);
      check1("b2b_busy", div_busy, 1'b1);
    end
    wait_done();

    // reset mid-operation discards the result
    @(posedge clk);
    #1;
    drive_op(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b1);
    repeat (14) @(posedge clk);
    #1;
    resetn = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_quotient", quotient, 32'h0);
    check("midrst_remainder", remainder, 32'h0);
    check1("midrst_busy", div_busy, 1'b0);
    check1("midrst_end", div_end, 1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    check1("post_rst_idle", div_busy, 1'b0);
    @(posedge clk);
    #1;
    drive_op(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b1);
    wait_done();

    for (int i = 0; i < 16; i++) begin
      s = 1'(i % 2);
      a = $urandom;
      if (i % 4 == 1)      b = -32'($urandom_range(1, 9));
      else if (i % 4 == 2) b = 32'($urandom_range(1, 20));
      else                 b = $urandom;
      model(s, a, b, eq, er);
      @(posedge clk);
      #1;
      drive_op(s, a, b, eq, er, 1'b1);
      wait_done();
    end

    repeat (5) @(negedge clk);
    check("sb_empty_final", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
